buton_buyruk_uretici: RTL and testbench
=======================================

BUTON_BUYRUK_URETICI -- requirements
Module: buton_buyruk_uretici

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16, number of consecutive cycles a synchronized button vector must stay unchanged to be accepted; legal range 2..65535.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: btn  input  4  raw board buttons, asynchronous to clk, bouncing; bit0 sol, bit1 sag, bit2 yukari, bit3 asagi.
REQ-005 Port: sayi1  input  3  operand A from switches, quasi-static.
REQ-006 Port: sayi2  input  3  operand B from switches, quasi-static.
REQ-007 Port: buyruk1  output  9  left-ALU instruction {opcode[8:6], A[5:3], B[2:0]}, registered.
REQ-008 Port: buyruk2  output  9  right-ALU instruction, same format, registered.
REQ-009 Port: gecerli  output  1  one-cycle pulse: new buyruk1/buyruk2 pair issued.
REQ-010 Port: hata  output  1  level: more than one button accepted as pressed.
REQ-011 Port: sayac  output  8  count of issued instruction pairs, wraps.

Function
REQ-012 btn SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-013 Debouncer SHALL hold cand[3:0], cnt (width ceil(log2(DEBOUNCE_CYCLES))), stable[3:0]: if s2 != cand then cand<=s2, cnt<=0; else if cnt==DEBOUNCE_CYCLES-1 then stable<=cand, cnt holds; else cnt<=cnt+1.
REQ-014 Glitch on s2 shorter than DEBOUNCE_CYCLES cycles SHALL leave stable unchanged.
REQ-015 FSM states: BOSTA (no buttons), BASILI (one-hot press accepted, waiting release), COKLU (multi-hot accepted, waiting release).
REQ-016 BOSTA: stable one-hot -> issue (REQ-017), go BASILI; stable with >=2 bits set -> go COKLU, no issue; stable==0 -> stay.
REQ-017 Issue SHALL, in one registered edge: buyruk1<={op1,sayi1,sayi2}, buyruk2<={op2,sayi1,sayi2}, gecerli<=1, sayac<=sayac+1 (mod 256).
REQ-018 Opcode map (op1/op2): bit0 -> 000/001; bit1 -> 010/011; bit2 -> 100/101; bit3 -> 110/111.
REQ-019 BASILI: stable==0 -> BOSTA; any other stable value (including change to another button or multi-hot) -> stay, no issue.
REQ-020 COKLU: hata=1 while in state; stable==0 -> BOSTA; otherwise stay; leaving to BASILI directly SHALL NOT occur.
REQ-021 hata SHALL be 0 in BOSTA and BASILI; decoded combinationally from state register only.
REQ-022 gecerli SHALL be high exactly one cycle per issue; holding a button SHALL NOT produce repeats.
REQ-023 buyruk1/buyruk2 SHALL hold last issued values between issues; sayi1/sayi2 changes without a new issue SHALL NOT affect them.
REQ-024 Latency: btn held constant from edge 0 (first sampling) -> gecerli high after edge DEBOUNCE_CYCLES+3, low after next edge.
REQ-025 sayi1/sayi2 sampled only at the issue edge; they SHALL be stable >=1 cycle before it (board-level guarantee, no synchronizer).

Reset
REQ-026 rst_n low SHALL immediately force: s1=s2=cand=stable=0, cnt=0, state=BOSTA, buyruk1=buyruk2=9'h000, gecerli=0, sayac=0, hata=0.
REQ-027 Reset during debounce or in BASILI/COKLU SHALL abort; a button still held after rst_n rises SHALL be debounced anew and issue once.
REQ-028 rst_n deassertion SHALL be synchronized externally; block requires no extra release logic.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 sayi1=3, sayi2=5, btn=0001 held -> after edge 7: buyruk1=9'h01D, buyruk2=9'h05D, gecerli=1 one cycle, sayac=1; no further pulses while held.
REQ-030 btn=0100 pulsed high 2 cycles, then 0 -> stable stays 0, gecerli never asserts, sayac=0.
REQ-031 btn=0011 held -> hata=1 from edge 7 until 0000 debounced, gecerli=0, buyruk unchanged, sayac unchanged.
REQ-032 btn=1000 press/release, then btn=0010 press with sayi1=7, sayi2=0 -> second issue buyruk1=9'h0B8, buyruk2=9'h0F8, sayac=2.
REQ-033 rst_n asserted at edge 5 of a btn=0001 press, released at edge 8, btn still held -> no gecerli before reset; gecerli after 7 edges from release; sayac=1.
REQ-034 256 press/release cycles -> sayac returns to 0 on the 256th issue, gecerli still pulses.

Source files
------------

// File: rtl/buton_buyruk_uretici.sv
// Debounced 4-button front end that issues paired ALU
// instructions built from the switch operands.
module buton_buyruk_uretici #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  input  logic [2:0] sayi1,
  input  logic [2:0] sayi2,
  output logic [8:0] buyruk1,
  output logic [8:0] buyruk2,
  output logic       gecerli,
  output logic       hata,
  output logic [7:0] sayac
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    BOSTA,
    BASILI,
    COKLU
  } durum_t;

  logic [3:0]    s1;
  logic [3:0]    s2;
  logic [3:0]    cand;
  logic [CW-1:0] cnt;
  logic [3:0]    stable;

  durum_t durum;
  durum_t durum_n;

  logic       tek;
  logic       coklu;
  logic       issue;
  logic [3:0] sel;
  logic [2:0] op1;
  logic [2:0] op2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 4'd0;
      s2 <= 4'd0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // A new sample restarts the window; stable updates only
  // once cand has survived DEBOUNCE_CYCLES unchanged samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand   <= 4'd0;
      cnt    <= '0;
      stable <= 4'd0;
    end else if (s2 != cand) begin
      cand <= s2;
      cnt  <= '0;
    end else if (cnt == CMAX) begin
      stable <= cand;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tek   = (stable != 4'd0) &&
                 ((stable & (stable - 4'd1)) == 4'd0);
  assign coklu = (stable != 4'd0) && !tek;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum <= BOSTA;
    end else begin
      durum <= durum_n;
    end
  end

  always_comb begin
    durum_n = durum;
    issue   = 1'b0;
    unique case (durum)
      BOSTA: begin
        if (tek) begin
          issue   = 1'b1;
          durum_n = BASILI;
        end else if (coklu) begin
          durum_n = COKLU;
        end
      end
      BASILI: begin
        if (stable == 4'd0) durum_n = BOSTA;
      end
      COKLU: begin
        if (stable == 4'd0) durum_n = BOSTA;
      end
      default: durum_n = BOSTA;
    endcase
  end

  assign sel = tek ? stable : 4'd0;

  always_comb begin
    op1 = 3'b000;
    unique case (1'b1)
      sel[0]:  op1 = 3'b000;
      sel[1]:  op1 = 3'b010;
      sel[2]:  op1 = 3'b100;
      sel[3]:  op1 = 3'b110;
      default: op1 = 3'b000;
    endcase
  end

  assign op2 = {op1[2:1], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buyruk1 <= 9'h000;
      buyruk2 <= 9'h000;
      gecerli <= 1'b0;
      sayac   <= 8'd0;
    end else begin
      gecerli <= issue;
      if (issue) begin
        buyruk1 <= {op1, sayi1, sayi2};
        buyruk2 <= {op2, sayi1, sayi2};
        sayac   <= sayac + 8'd1;
      end
    end
  end

  assign hata = (durum == COKLU);

endmodule

// File: tb/tb_buton_buyruk_uretici.sv
// Directed bench for buton_buyruk_uretici with
// DEBOUNCE_CYCLES=4 (issue lands on edge 7).
module tb_buton_buyruk_uretici;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic [2:0] sayi1;
  logic [2:0] sayi2;
  logic [8:0] buyruk1;
  logic [8:0] buyruk2;
  logic       gecerli;
  logic       hata;
  logic [7:0] sayac;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int p0;

  always #5 clk = ~clk;

  buton_buyruk_uretici #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn),
    .sayi1  (sayi1),
    .sayi2  (sayi2),
    .buyruk1(buyruk1),
    .buyruk2(buyruk2),
    .gecerli(gecerli),
    .hata   (hata),
    .sayac  (sayac)
  );

  always @(negedge clk) begin
    if (gecerli === 1'b1) pulses++;
  end

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic edges(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 4'd0;
    sayi1 = 3'd0;
    sayi2 = 3'd0;
    edges(3);
    chk("rst_b1", buyruk1, 9'h000);
    chk("rst_b2", buyruk2, 9'h000);
    chk("rst_gec", gecerli, 1'b0);
    chk("rst_hata", hata, 1'b0);
    chk("rst_sayac", sayac, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    edges(10);

    // single press, edge 0 is the first posedge after drive
    @(negedge clk);
    sayi1 = 3'd3;
    sayi2 = 3'd5;
    btn   = 4'b0001;
    p0    = pulses;
    edges(7);
    chk("t29_pre", gecerli, 1'b0);
    edges(1);
    chk("t29_gec", gecerli, 1'b1);
    chk("t29_b1", buyruk1, 9'h01D);
    chk("t29_b2", buyruk2, 9'h05D);
    chk("t29_sayac", sayac, 8'd1);
    chk("t29_hata", hata, 1'b0);
    edges(1);
    chk("t29_gec_low", gecerli, 1'b0);
    @(negedge clk);
    sayi1 = 3'd6;
    sayi2 = 3'd2;
    edges(20);
    chk("t29_held", pulses - p0, 1);
    chk("t23_hold_b1", buyruk1, 9'h01D);
    chk("t23_hold_b2", buyruk2, 9'h05D);
    @(negedge clk);
    btn = 4'b0010;
    edges(20);
    chk("t19_switch", pulses - p0, 1);
    chk("t19_sayac", sayac, 8'd1);
    @(negedge clk);
    btn = 4'b0000;
    edges(12);

    // two-cycle glitch
    p0 = pulses;
    @(negedge clk);
    btn = 4'b0100;
    edges(2);
    @(negedge clk);
    btn = 4'b0000;
    edges(20);
    chk("t30_pulses", pulses - p0, 0);
    chk("t30_sayac", sayac, 8'd1);
    chk("t30_b1", buyruk1, 9'h01D);

    // multi-button press
    p0 = pulses;
    @(negedge clk);
    btn = 4'b0011;
    edges(7);
    chk("t31_hata_pre", hata, 1'b0);
    edges(1);
    chk("t31_hata", hata, 1'b1);
    chk("t31_gec", gecerli, 1'b0);
    edges(15);
    chk("t31_hata_hold", hata, 1'b1);
    @(negedge clk);
    btn = 4'b0000;
    edges(7);
    chk("t31_hata_rel", hata, 1'b1);
    edges(1);
    chk("t31_hata_clr", hata, 1'b0);
    chk("t31_pulses", pulses - p0, 0);
    chk("t31_sayac", sayac, 8'd1);
    chk("t31_b1", buyruk1, 9'h01D);
    chk("t31_b2", buyruk2, 9'h05D);
    edges(4);

    // two sequential issues
    @(negedge clk);
    sayi1 = 3'd1;
    sayi2 = 3'd2;
    btn   = 4'b1000;
    edges(8);
    chk("t32a_gec", gecerli, 1'b1);
    chk("t32a_b1", buyruk1, 9'h18A);
    chk("t32a_b2", buyruk2, 9'h1CA);
    chk("t32a_sayac", sayac, 8'd2);
    @(negedge clk);
    btn = 4'b0000;
    edges(12);
    @(negedge clk);
    sayi1 = 3'd7;
    sayi2 = 3'd0;
    btn   = 4'b0010;
    edges(8);
    chk("t32b_gec", gecerli, 1'b1);
    chk("t32b_b1", buyruk1, 9'h0B8);
    chk("t32b_b2", buyruk2, 9'h0F8);
    chk("t32b_sayac", sayac, 8'd3);
    @(negedge clk);
    btn = 4'b0000;
    edges(12);

    // reset in the middle of a debounce
    p0 = pulses;
    @(negedge clk);
    btn = 4'b0001;
    edges(5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t33_rst_sayac", sayac, 8'd0);
    chk("t33_rst_b1", buyruk1, 9'h000);
    edges(3);
    chk("t33_rst_pul", pulses - p0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    edges(7);
    chk("t33_pre", gecerli, 1'b0);
    edges(1);
    chk("t33_gec", gecerli, 1'b1);
    chk("t33_sayac", sayac, 8'd1);
    chk("t33_b1", buyruk1, 9'h038);
    chk("t33_b2", buyruk2, 9'h078);
    @(negedge clk);
    btn = 4'b0000;
    edges(12);
    chk("t33_pulses", pulses - p0, 1);

    // counter wrap
    @(negedge clk);
    rst_n = 1'b0;
    edges(2);
    @(negedge clk);
    rst_n = 1'b1;
    sayi1 = 3'd2;
    sayi2 = 3'd4;
    p0    = pulses;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      btn = 4'(1 << (i % 4));
      edges(8);
      chk("t34_gec", gecerli, 1'b1);
      chk("t34_sayac", sayac, (i + 1) % 256);
      @(negedge clk);
      btn = 4'b0000;
      edges(10);
    end
    chk("t34_pulses", pulses - p0, 256);
    chk("t34_wrap", sayac, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
